// File: rtl/dmux_pkg.sv
// Default geometry shared by dmux instances and their users.
package dmux_pkg;

    localparam int DMUX_DATA_W_DEF = 1;
    localparam int DMUX_SEL_W_DEF  = 2;

endpackage

// File: rtl/dmux.sv
// Registered 1-to-N demultiplexer: i is steered to lane[sel], all other lanes are zero.
// The output is a flop, so the result shows up one clock after i/sel are sampled.
module dmux
    import dmux_pkg::*;
#(
    parameter int DATA_W  = DMUX_DATA_W_DEF,
    parameter int SEL_W   = DMUX_SEL_W_DEF,
    // Derived from SEL_W. Overriding it is not supported.
    parameter int NUM_OUT = 2**SEL_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           i,
    input  logic [SEL_W-1:0]            sel,
    output logic [NUM_OUT*DATA_W-1:0]   out
);

    logic [NUM_OUT*DATA_W-1:0] out_next;

    // Next-state vector: the selected lane takes i, every other lane is cleared.
    function automatic logic [NUM_OUT*DATA_W-1:0] route(
        input logic [DATA_W-1:0] din,
        input logic [SEL_W-1:0]  lane_sel
    );
        logic [NUM_OUT*DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (SEL_W'(k) == lane_sel) begin
                v[k*DATA_W +: DATA_W] = din;
            end
        end
        return v;
    endfunction

    // Combinational lane decode ahead of the output register.
    always_comb begin
        out_next = route(i, sel);
    end

    // Output register; reset wins over the data path, and every other edge rewrites all lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_dmux.sv
// Self-checking bench for dmux: default 1x4 instance plus an 8-bit, 8-lane instance.
// Expected outputs come from a shift-based model; directed literal checks pin the model.
module tb_dmux;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  i4;
    logic [1:0]  sel4;
    logic [3:0]  out4;
    logic        rst8;
    logic [7:0]  i8;
    logic [2:0]  sel8;
    logic [63:0] out8;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp4;
    logic [63:0] exp8;
    logic        model_valid = 1'b0;

    always #5 clk = ~clk;

    dmux u_dut4 (
        .clk (clk),
        .rst (rst),
        .i   (i4),
        .sel (sel4),
        .out (out4)
    );

    dmux #(.DATA_W(8), .SEL_W(3)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .i   (i8),
        .sel (sel8),
        .out (out8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the value each output register must hold after this edge.
    always @(posedge clk) begin
        exp4 <= rst  ? 64'd0 : (64'(i4) << (32'(sel4) * 1));
        exp8 <= rst8 ? 64'd0 : (64'(i8) << (32'(sel8) * 8));
        model_valid <= 1'b1;
    end

    // Compare both instances against the model midway through every cycle.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_out4", 64'(out4), exp4);
            chk("model_out8", out8, exp8);
        end
    end

    initial begin
        $monitor("t=%0t rst=%b i=%b sel=%b out=%b", $time, rst, i4, sel4, out4);
    end

    initial begin
        logic [3:0] sweep_exp [4];
        sweep_exp[0] = 4'b0001;
        sweep_exp[1] = 4'b0010;
        sweep_exp[2] = 4'b0100;
        sweep_exp[3] = 4'b1000;

        rst  = 1'b1; i4 = 1'b1; sel4 = 2'b10;
        rst8 = 1'b1; i8 = 8'hA5; sel8 = 3'd6;

        // Reset held for two edges with live data on the inputs.
        repeat (2) @(posedge clk);
        #2;
        chk("reset_out4", 64'(out4), 64'h0);
        chk("reset_out8", out8, 64'h0);

        // Walk i=1 across every lane.
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            rst  = 1'b0;
            i4   = 1'b1;
            sel4 = 2'(s);
            if (s == 0) begin
                #1;
                chk("first_cycle_after_reset", 64'(out4), 64'h0);
            end
            @(posedge clk);
            #2;
            chk("sweep_one", 64'(out4), 64'(sweep_exp[s]));
        end

        // Wide instance: lane 6 occupies bits 55:48.
        @(negedge clk);
        rst8 = 1'b0; i8 = 8'hA5; sel8 = 3'd6;
        @(posedge clk);
        #2;
        chk("wide_lane6", out8, 64'h00A5_0000_0000_0000);

        // i=0 clears every lane regardless of sel.
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            i4 = 1'b0; sel4 = 2'(s);
            @(posedge clk);
            #2;
            chk("sweep_zero", 64'(out4), 64'h0);
        end

        // Latency: sel moves 00 -> 11, out only follows at the next edge.
        @(negedge clk);
        i4 = 1'b1; sel4 = 2'b00;
        @(posedge clk);
        #2;
        chk("latency_pre", 64'(out4), 64'h1);
        @(negedge clk);
        sel4 = 2'b11;
        #1;
        chk("latency_before_edge", 64'(out4), 64'h1);
        @(posedge clk);
        #2;
        chk("latency_after_edge", 64'(out4), 64'h8);

        // Mid-stream reset discards the data sampled on that edge.
        @(negedge clk);
        rst = 1'b1; i4 = 1'b1; sel4 = 2'b01;
        @(posedge clk);
        #2;
        chk("midreset_clear", 64'(out4), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_hold", 64'(out4), 64'h0);
        @(posedge clk);
        #2;
        chk("midreset_resume", 64'(out4), 64'h2);

        $monitoroff;

        // Randomised traffic with occasional resets, checked by the model process.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 19) == 0);
            rst8 = ($urandom_range(0, 19) == 0);
            i4   = 1'($urandom);
            sel4 = 2'($urandom);
            i8   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            sel8 = 3'($urandom);
        end

        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
